hazard_ctrl: RTL and testbench

Register-hazard scheduler for the single-issue pipeline. Tracks in-flight register writes in a scoreboard shift register that mirrors the write-back delay line, and stalls issue whenever the decoding instruction reads a register with a pending write. Also freezes issue and scoreboard on a memory hold. Sits beside `Control`: its `stall` is ORed into the PC-hold and bubble-insert logic, and its scoreboard advances in lock-step with the reg-write/reg-dst/load delay lines.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_sb_match.sv | 35 +++
 rtl/hazard_ctrl.sv | 94 +++++++++
 tb/tb_hazard_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline types for the register-hazard scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  // Register-index width of the single-issue pipeline.
  localparam int REG_W = 5;

  // Register 0 is hard-wired to zero: writes are dropped and reads never wait.
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // One scoreboard slot: a pending write to register r.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] r;
  } sb_entry_t;

endpackage

// File: rtl/hazard_ctrl_sb_match.sv
// Compares one decode source against every scoreboard slot.
// Latency: combinational.
// Backpressure: none; the hit feeds the stall logic of the parent.
//
// Ports:
//   slots   - scoreboard, slot 0 newest, slot DEPTH-1 writing back now
//   src     - register index read by the decoding instruction
//   use_src - the instruction really reads src
//   hit     - src has a pending write that the register file cannot forward
module sb_match
  import hazard_ctrl_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter bit BYPASS = 1'b1
) (
  input  sb_entry_t [DEPTH-1:0] slots,
  input  logic [REG_W-1:0]      src,
  input  logic                  use_src,
  output logic                  hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      // With bypass the register file returns the value being written this
      // cycle, so the write-back slot can be ignored.
      if (!(BYPASS && (i == DEPTH - 1)) &&
          slots[i].v && (slots[i].r == src) &&
          use_src && (src != REG_ZERO)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Register-hazard scheduler: scoreboard of in-flight writes, stalls RAW reads.
// Latency: stall is combinational from inputs and state; scoreboard steps per edge.
// Backpressure: hold freezes scoreboard and counter and forces stall high.
//
// Ports:
//   clk, rst              - clock (rising edge), async active-low reset
//   issue_valid           - real instruction in decode
//   src_a/src_b, use_a/b  - source registers and their read enables
//   dst, dst_we           - destination register and its write enable
//   hold                  - memory not ready, back end frozen
//   stall                 - hold PC, insert bubble
//   busy                  - at least one pending write
//   stall_cnt             - saturating count of data-hazard stall cycles
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] src_a,
  input  logic [REG_W-1:0] src_b,
  input  logic             use_a,
  input  logic             use_b,
  input  logic [REG_W-1:0] dst,
  input  logic             dst_we,
  input  logic             hold,
  output logic             stall,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                  hit_a, hit_b, hazard;

  sb_match #(.DEPTH(DEPTH), .BYPASS(BYPASS)) u_match_a (
    .slots   (sb_q),
    .src     (src_a),
    .use_src (use_a),
    .hit     (hit_a)
  );

  sb_match #(.DEPTH(DEPTH), .BYPASS(BYPASS)) u_match_b (
    .slots   (sb_q),
    .src     (src_b),
    .use_src (use_b),
    .hit     (hit_b)
  );

  // A hit on both sources is still a single stall cycle.
  assign hazard = issue_valid & (hit_a | hit_b);
  assign stall  = hold | hazard;

  always_comb begin
    sb_d        = sb_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      // Shift toward write-back, in step with the datapath delay lines.
      for (int i = DEPTH - 1; i > 0; i--) begin
        sb_d[i] = sb_q[i-1];
      end
      // A stalled or empty decode slot enters as a bubble; r0 writes are dropped.
      sb_d[0].v = issue_valid & ~stall & dst_we & (dst != REG_ZERO);
      sb_d[0].r = dst;
      if (hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy = busy | sb_q[i].v;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid = 1'b0;
  logic [4:0] src_a = '0, src_b = '0, dst = '0;
  logic       use_a = 1'b0, use_b = 1'b0, dst_we = 1'b0, hold = 1'b0;

  // b1: DEPTH=2 BYPASS=1, b0: DEPTH=2 BYPASS=0, c4: CNT_W=4, d1: DEPTH=1 BYPASS=1
  logic        st_b1, bz_b1, st_b0, bz_b0, st_c4, bz_c4, st_d1, bz_d1;
  logic [15:0] cn_b1, cn_b0, cn_d1;
  logic [3:0]  cn_c4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DEPTH(2), .BYPASS(1'b1), .CNT_W(16)) dut_b1 (
    .clk(clk), .rst(rst_n), .issue_valid(issue_valid), .src_a(src_a), .src_b(src_b),
    .use_a(use_a), .use_b(use_b), .dst(dst), .dst_we(dst_we), .hold(hold),
    .stall(st_b1), .busy(bz_b1), .stall_cnt(cn_b1));

  hazard_ctrl #(.DEPTH(2), .BYPASS(1'b0), .CNT_W(16)) dut_b0 (
    .clk(clk), .rst(rst_n), .issue_valid(issue_valid), .src_a(src_a), .src_b(src_b),
    .use_a(use_a), .use_b(use_b), .dst(dst), .dst_we(dst_we), .hold(hold),
    .stall(st_b0), .busy(bz_b0), .stall_cnt(cn_b0));

  hazard_ctrl #(.DEPTH(2), .BYPASS(1'b1), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst_n), .issue_valid(issue_valid), .src_a(src_a), .src_b(src_b),
    .use_a(use_a), .use_b(use_b), .dst(dst), .dst_we(dst_we), .hold(hold),
    .stall(st_c4), .busy(bz_c4), .stall_cnt(cn_c4));

  hazard_ctrl #(.DEPTH(1), .BYPASS(1'b1), .CNT_W(16)) dut_d1 (
    .clk(clk), .rst(rst_n), .issue_valid(issue_valid), .src_a(src_a), .src_b(src_b),
    .use_a(use_a), .use_b(use_b), .dst(dst), .dst_we(dst_we), .hold(hold),
    .stall(st_d1), .busy(bz_d1), .stall_cnt(cn_d1));

  // Drive one decode slot; outputs are sampled 1 ns later, well before the edge.
  task automatic drive(input logic v, input logic [4:0] sa, input logic ua,
                       input logic [4:0] sb, input logic ub,
                       input logic [4:0] d, input logic we, input logic h);
    issue_valid = v; src_a = sa; use_a = ua; src_b = sb; use_b = ub;
    dst = d; dst_we = we; hold = h;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #2;
    total++; if (st_b1 !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", st_b1); end
    total++; if (bz_b1 !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bz_b1); end
    total++; if (cn_b1 !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", cn_b1); end
    total++; if (bz_b0 !== 1'b0) begin bad++; $display("FAIL rst_busy_b0 got=%b exp=0", bz_b0); end
    total++; if (cn_c4 !== 4'd0) begin bad++; $display("FAIL rst_cnt_c4 got=%0d exp=0", cn_c4); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_adjacent();
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);  // producer r8
    total++; if (st_b1 !== 1'b0) begin bad++; $display("FAIL adj_prod_stall got=%b exp=0", st_b1); end
    tick();
    total++; if (bz_b1 !== 1'b1) begin bad++; $display("FAIL adj_busy got=%b exp=1", bz_b1); end
    total++; if (bz_d1 !== 1'b1) begin bad++; $display("FAIL adj_busy_d1 got=%b exp=1", bz_d1); end
    drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);  // consumer reads r8
    total++; if (st_b1 !== 1'b1) begin bad++; $display("FAIL adj_b1_c0 got=%b exp=1", st_b1); end
    total++; if (st_b0 !== 1'b1) begin bad++; $display("FAIL adj_b0_c0 got=%b exp=1", st_b0); end
    total++; if (st_d1 !== 1'b0) begin bad++; $display("FAIL adj_d1 got=%b exp=0", st_d1); end
    tick();
    total++; if (st_b1 !== 1'b0) begin bad++; $display("FAIL adj_b1_c1 got=%b exp=0", st_b1); end
    total++; if (st_b0 !== 1'b1) begin bad++; $display("FAIL adj_b0_c1 got=%b exp=1", st_b0); end
    tick();
    total++; if (st_b0 !== 1'b0) begin bad++; $display("FAIL adj_b0_c2 got=%b exp=0", st_b0); end
    tick();
    idle();
    total++; if (cn_b1 !== 16'd1) begin bad++; $display("FAIL adj_cnt_b1 got=%0d exp=1", cn_b1); end
    total++; if (cn_b0 !== 16'd2) begin bad++; $display("FAIL adj_cnt_b0 got=%0d exp=2", cn_b0); end
    total++; if (bz_b1 !== 1'b0) begin bad++; $display("FAIL adj_busy_end got=%b exp=0", bz_b1); end
  endtask

  task automatic test_r0();
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);  // write to r0
    tick();
    total++; if (bz_b0 !== 1'b0) begin bad++; $display("FAIL r0_busy got=%b exp=0", bz_b0); end
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    total++; if (st_b0 !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b exp=0", st_b0); end
    tick();
    idle();
    total++; if (cn_b0 !== 16'd0) begin bad++; $display("FAIL r0_cnt got=%0d exp=0", cn_b0); end
  endtask

  task automatic test_independent();
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);  // producer r5
    tick();
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);  // independent
    total++; if (st_b0 !== 1'b0) begin bad++; $display("FAIL ind_mid got=%b exp=0", st_b0); end
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);  // consumer via B
    total++; if (st_b1 !== 1'b0) begin bad++; $display("FAIL ind_b1 got=%b exp=0", st_b1); end
    total++; if (st_b0 !== 1'b1) begin bad++; $display("FAIL ind_b0_c0 got=%b exp=1", st_b0); end
    tick();
    total++; if (st_b0 !== 1'b0) begin bad++; $display("FAIL ind_b0_c1 got=%b exp=0", st_b0); end
    tick();
    idle();
    total++; if (cn_b1 !== 16'd0) begin bad++; $display("FAIL ind_cnt_b1 got=%0d exp=0", cn_b1); end
    total++; if (cn_b0 !== 16'd1) begin bad++; $display("FAIL ind_cnt_b0 got=%0d exp=1", cn_b0); end
  endtask

  task automatic test_both_sources();
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
    total++; if (st_b1 !== 1'b1) begin bad++; $display("FAIL both_stall got=%b exp=1", st_b1); end
    tick();
    idle();
    total++; if (cn_b1 !== 16'd1) begin bad++; $display("FAIL both_cnt got=%0d exp=1", cn_b1); end
  endtask

  task automatic test_hold();
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      total++; if (st_b1 !== 1'b1) begin bad++; $display("FAIL hold_b1_%0d got=%b exp=1", k, st_b1); end
      total++; if (st_d1 !== 1'b1) begin bad++; $display("FAIL hold_d1_%0d got=%b exp=1", k, st_d1); end
      tick();
      total++; if (cn_b0 !== 16'd0) begin bad++; $display("FAIL hold_cnt_%0d got=%0d exp=0", k, cn_b0); end
      total++; if (bz_b1 !== 1'b1) begin bad++; $display("FAIL hold_busy_%0d got=%b exp=1", k, bz_b1); end
    end
    drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    total++; if (st_b1 !== 1'b1) begin bad++; $display("FAIL post_b1_c0 got=%b exp=1", st_b1); end
    total++; if (st_b0 !== 1'b1) begin bad++; $display("FAIL post_b0_c0 got=%b exp=1", st_b0); end
    tick();
    total++; if (st_b1 !== 1'b0) begin bad++; $display("FAIL post_b1_c1 got=%b exp=0", st_b1); end
    total++; if (st_b0 !== 1'b1) begin bad++; $display("FAIL post_b0_c1 got=%b exp=1", st_b0); end
    tick();
    total++; if (st_b0 !== 1'b0) begin bad++; $display("FAIL post_b0_c2 got=%b exp=0", st_b0); end
    tick();
    idle();
    total++; if (cn_b1 !== 16'd1) begin bad++; $display("FAIL post_cnt_b1 got=%0d exp=1", cn_b1); end
    total++; if (cn_b0 !== 16'd2) begin bad++; $display("FAIL post_cnt_b0 got=%0d exp=2", cn_b0); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();   // one stall recorded, r9 still pending
    total++; if (cn_b1 !== 16'd1) begin bad++; $display("FAIL mid_pre_cnt got=%0d exp=1", cn_b1); end
    total++; if (bz_b1 !== 1'b1) begin bad++; $display("FAIL mid_pre_busy got=%b exp=1", bz_b1); end
    idle();
    rst_n = 1'b0;
    #1;
    total++; if (bz_b1 !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", bz_b1); end
    total++; if (cn_b1 !== 16'd0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", cn_b1); end
    tick();
    rst_n = 1'b1;
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    total++; if (st_b0 !== 1'b0) begin bad++; $display("FAIL mid_consumer got=%b exp=0", st_b0); end
    tick();
    idle();
  endtask

  // Self-dependent r8 instruction: with bypass it alternates issue / stall.
  task automatic test_saturate();
    do_reset();
    drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    total++; if (st_b1 !== 1'b0) begin bad++; $display("FAIL sat_first got=%b exp=0", st_b1); end
    for (int k = 0; k < 10; k++) tick();
    total++; if (cn_c4 !== 4'd5) begin bad++; $display("FAIL sat_c4_10 got=%0d exp=5", cn_c4); end
    for (int k = 0; k < 50; k++) tick();
    idle();
    total++; if (cn_c4 !== 4'd15) begin bad++; $display("FAIL sat_c4_60 got=%0d exp=15", cn_c4); end
    total++; if (cn_b1 !== 16'd30) begin bad++; $display("FAIL sat_b1_60 got=%0d exp=30", cn_b1); end
    total++; if (cn_d1 !== 16'd0) begin bad++; $display("FAIL sat_d1 got=%0d exp=0", cn_d1); end
    total++; if (bz_c4 !== 1'b1) begin bad++; $display("FAIL sat_busy got=%b exp=1", bz_c4); end
  endtask

  initial begin
    test_reset();
    test_adjacent();
    test_r0();
    test_independent();
    test_both_sources();
    test_hold();
    test_reset_midop();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
